// File: rtl/rf_window_scanner.sv
// rf_window_scanner: sweeps a ROWS x COLS window over a multi-channel image
// stack, fetching one pixel per accepted memory beat and presenting each
// completed CHANNELS x ROWS x COLS window under a valid/ready handshake.
module rf_window_scanner #(
    parameter int ADDR_BITS  = 16,
    parameter int WORD_BITS  = 8,
    parameter int IMG_HEIGHT = 28,
    parameter int IMG_WIDTH  = 28,
    parameter int ROWS       = 3,
    parameter int COLS       = 3,
    parameter int CHANNELS   = 2,
    parameter int STRIDE     = 1,
    parameter int NUM_IMGS   = 4,
    localparam int XW        = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1,
    localparam int YW        = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1,
    localparam int IW        = (NUM_IMGS   > 1) ? $clog2(NUM_IMGS)   : 1,
    localparam int RF_W      = CHANNELS * ROWS * COLS * WORD_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 addr_clear,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_req,
    input  logic [WORD_BITS-1:0] mem_word,
    input  logic                 data_valid,
    output logic [RF_W-1:0]      rf,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XW-1:0]        win_x,
    output logic [YW-1:0]        win_y,
    output logic [IW-1:0]        img_idx,
    output logic                 last_win
);

    // A zero stride is rejected below; clamp here so the grid math stays defined.
    localparam int SAFE_STRIDE = (STRIDE < 1) ? 1 : STRIDE;
    localparam int PLANE       = IMG_HEIGHT * IMG_WIDTH;
    localparam int IMG_SZ      = CHANNELS * PLANE;
    localparam int NX          = (IMG_WIDTH  - COLS) / SAFE_STRIDE + 1;
    localparam int NY          = (IMG_HEIGHT - ROWS) / SAFE_STRIDE + 1;
    localparam int CHW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int RW          = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CLW         = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int NXW         = (NX > 1) ? $clog2(NX) : 1;
    localparam int NYW         = (NY > 1) ? $clog2(NY) : 1;

    if (ROWS > IMG_HEIGHT || COLS > IMG_WIDTH || STRIDE < 1 ||
        (longint'(NUM_IMGS) * longint'(IMG_SZ)) > (longint'(1) << ADDR_BITS)) begin : g_cfg_check
        $fatal(1, "rf_window_scanner: illegal parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;

    state_t           state_q, state_d;
    logic [CHW-1:0]   ch_q, ch_d;
    logic [RW-1:0]    r_q, r_d;
    logic [CLW-1:0]   c_q, c_d;
    logic [NXW-1:0]   ix_q, ix_d;
    logic [NYW-1:0]   iy_q, iy_d;
    logic [IW-1:0]    img_q, img_d;
    logic [RF_W-1:0]  rf_q, rf_d;

    logic [ADDR_BITS-1:0] addr_w;
    logic [31:0]          pix_idx;
    logic                 last_w;

    // Pixel address of the current (ch, r, c) inside the current window; wraps at ADDR_BITS.
    always_comb begin
        addr_w = ADDR_BITS'(32'(img_q) * 32'(IMG_SZ)
                          + 32'(ch_q) * 32'(PLANE)
                          + (32'(iy_q) * 32'(SAFE_STRIDE) + 32'(r_q)) * 32'(IMG_WIDTH)
                          + 32'(ix_q) * 32'(SAFE_STRIDE) + 32'(c_q));
        pix_idx = (32'(ch_q) * 32'(ROWS) + 32'(r_q)) * 32'(COLS) + 32'(c_q);
        last_w  = (ix_q == NXW'(NX - 1)) && (iy_q == NYW'(NY - 1));
    end

    // Next-state: pixel counters (c fastest, then r, then ch), window grid, image index, buffer.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        r_d     = r_q;
        c_d     = c_q;
        ix_d    = ix_q;
        iy_d    = iy_q;
        img_d   = img_q;
        rf_d    = rf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    ch_d    = '0;
                    r_d     = '0;
                    c_d     = '0;
                end
            end
            S_FETCH: begin
                if (data_valid) begin
                    rf_d[pix_idx * WORD_BITS +: WORD_BITS] = mem_word;
                    if (c_q == CLW'(COLS - 1)) begin
                        c_d = '0;
                        if (r_q == RW'(ROWS - 1)) begin
                            r_d = '0;
                            if (ch_q == CHW'(CHANNELS - 1)) begin
                                ch_d    = '0;
                                state_d = S_HOLD;
                            end else begin
                                ch_d = ch_q + CHW'(1);
                            end
                        end else begin
                            r_d = r_q + RW'(1);
                        end
                    end else begin
                        c_d = c_q + CLW'(1);
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    if (last_w) begin
                        ix_d    = '0;
                        iy_d    = '0;
                        img_d   = (img_q == IW'(NUM_IMGS - 1)) ? '0 : img_q + IW'(1);
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_FETCH;
                        if (ix_q == NXW'(NX - 1)) begin
                            ix_d = '0;
                            iy_d = iy_q + NYW'(1);
                        end else begin
                            ix_d = ix_q + NXW'(1);
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Restart wins over everything, including a same-cycle handshake.
        if (addr_clear) begin
            state_d = S_IDLE;
            ch_d    = '0;
            r_d     = '0;
            c_d     = '0;
            ix_d    = '0;
            iy_d    = '0;
            img_d   = '0;
            rf_d    = '0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            r_q     <= '0;
            c_q     <= '0;
            ix_q    <= '0;
            iy_q    <= '0;
            img_q   <= '0;
            rf_q    <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            r_q     <= r_d;
            c_q     <= c_d;
            ix_q    <= ix_d;
            iy_q    <= iy_d;
            img_q   <= img_d;
            rf_q    <= rf_d;
        end
    end

    assign mem_req   = (state_q == S_FETCH);
    assign mem_addr  = (state_q == S_FETCH) ? addr_w : '0;
    assign out_valid = (state_q == S_HOLD);
    assign last_win  = (state_q == S_HOLD) && last_w;
    assign rf        = rf_q;
    assign win_x     = XW'(32'(ix_q) * 32'(SAFE_STRIDE));
    assign win_y     = YW'(32'(iy_q) * 32'(SAFE_STRIDE));
    assign img_idx   = img_q;

endmodule

// File: tb/tb_rf_window_scanner.sv
// Scoreboard bench: stimulus pushes expected addresses/windows, negedge monitors pop and compare.
module tb_rf_window_scanner;

    logic clk, rst, start, addr_clear, dv, ordy;
    logic [15:0] mem_addr;
    logic        mem_req;
    logic [7:0]  mem_word;
    logic [31:0] rf;
    logic        out_valid, last_win;
    logic [1:0]  win_x, win_y;
    logic        img_idx;

    // second instance: two channels, stride 1
    logic        start2, clr2, dv2, ordy2;
    logic [15:0] mem_addr2;
    logic        mem_req2;
    logic [7:0]  mem_word2;
    logic [63:0] rf2;
    logic        out_valid2, last_win2;
    logic [1:0]  win_x2, win_y2, img_idx2;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0]  x;
        logic [1:0]  y;
        logic        img;
        logic        last;
        logic [31:0] rf;
    } win_t;

    win_t        exp_win[$];
    logic [15:0] exp_addr[$];
    logic [15:0] exp_addr2[$];
    logic [63:0] exp_rf2[$];
    int          win2_cnt = 0;
    logic        seen_last2 = 1'b0;

    function automatic logic [7:0] w(input logic [15:0] a);
        return a[7:0] * 8'd3 + 8'h11;
    endfunction

    assign mem_word  = w(mem_addr);
    assign mem_word2 = w(mem_addr2);

    rf_window_scanner #(
        .ADDR_BITS(16), .WORD_BITS(8), .IMG_HEIGHT(4), .IMG_WIDTH(4),
        .ROWS(2), .COLS(2), .CHANNELS(1), .STRIDE(2), .NUM_IMGS(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .addr_clear(addr_clear),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_word(mem_word),
        .data_valid(dv), .rf(rf), .out_valid(out_valid), .out_ready(ordy),
        .win_x(win_x), .win_y(win_y), .img_idx(img_idx), .last_win(last_win)
    );

    rf_window_scanner #(
        .ADDR_BITS(16), .WORD_BITS(8), .IMG_HEIGHT(4), .IMG_WIDTH(4),
        .ROWS(2), .COLS(2), .CHANNELS(2), .STRIDE(1), .NUM_IMGS(4)
    ) dut2 (
        .clk(clk), .rst(rst), .start(start2), .addr_clear(clr2),
        .mem_addr(mem_addr2), .mem_req(mem_req2), .mem_word(mem_word2),
        .data_valid(dv2), .rf(rf2), .out_valid(out_valid2), .out_ready(ordy2),
        .win_x(win_x2), .win_y(win_y2), .img_idx(img_idx2), .last_win(last_win2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_win(input logic [1:0] x, input logic [1:0] y, input logic img,
                            input logic last, input logic [15:0] a0, input logic [15:0] a1,
                            input logic [15:0] a2, input logic [15:0] a3,
                            output logic [31:0] rf_exp);
        win_t e;
        exp_addr.push_back(a0);
        exp_addr.push_back(a1);
        exp_addr.push_back(a2);
        exp_addr.push_back(a3);
        rf_exp = {w(a3), w(a2), w(a1), w(a0)};
        e.x = x; e.y = y; e.img = img; e.last = last; e.rf = rf_exp;
        exp_win.push_back(e);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_win.size() > 0 && n < 300) begin
            tick();
            n++;
        end
        if (exp_win.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout pending=%0d required=0", name, exp_win.size());
            exp_win.delete();
            exp_addr.delete();
        end
    endtask

    // Five cycles in HOLD with out_ready low and stray data_valid pulses.
    task automatic hold_checks(input logic [31:0] rf_exp, input logic [1:0] x,
                               input logic [1:0] y, input logic img);
        for (int i = 0; i < 5; i++) begin
            dv = i[0];
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_req", mem_req, 0);
            chk("hold_rf", rf, rf_exp);
            chk("hold_x", win_x, x);
            chk("hold_y", win_y, y);
            chk("hold_img", img_idx, img);
        end
        dv = 1'b1;
    endtask

    // Monitor: accepted reads, held addresses during stalls, and delivered windows.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req && dv) begin
                if (exp_addr.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_req addr=%0h required=none", mem_addr);
                end else begin
                    chk("addr", mem_addr, exp_addr.pop_front());
                end
            end else if (mem_req && !dv && exp_addr.size() > 0) begin
                chk("stall_addr", mem_addr, exp_addr[0]);
            end
            if (out_valid && ordy) begin
                if (exp_win.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_win x=%0d y=%0d required=none", win_x, win_y);
                end else begin
                    win_t e;
                    e = exp_win.pop_front();
                    chk("win_x", win_x, e.x);
                    chk("win_y", win_y, e.y);
                    chk("win_img", img_idx, e.img);
                    chk("win_last", last_win, e.last);
                    chk("win_rf", rf, e.rf);
                end
            end
        end
    end

    // Monitor for the two-channel instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req2 && exp_addr2.size() > 0)
                chk("addr2", mem_addr2, exp_addr2.pop_front());
            if (out_valid2) begin
                win2_cnt++;
                if (exp_rf2.size() > 0)
                    chk("rf2", rf2, exp_rf2.pop_front());
                if (last_win2) begin
                    seen_last2 = 1'b1;
                    chk("last2_x", win_x2, 2);
                    chk("last2_y", win_y2, 2);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rf0, rf_t;
        int n;
        rst = 1'b1; start = 1'b0; addr_clear = 1'b0; dv = 1'b1; ordy = 1'b0;
        start2 = 1'b0; clr2 = 1'b0; dv2 = 1'b1; ordy2 = 1'b1;
        repeat (3) tick();
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", last_win, 0);
        chk("rst_x", win_x, 0);
        chk("rst_y", win_y, 0);
        chk("rst_img", img_idx, 0);
        chk("rst_rf", rf, 0);
        chk("rst_req2", mem_req2, 0);
        rst = 1'b0;
        tick();

        // image 0, first window: latency and HOLD stability
        push_win(0, 0, 0, 0, 0, 1, 4, 5, rf0);
        start = 1'b1; tick(); start = 1'b0;
        chk("first_req", mem_req, 1);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        chk("latency", n, 4);
        hold_checks(rf0, 0, 0, 0);
        push_win(2, 0, 0, 0, 2, 3, 6, 7, rf_t);
        push_win(0, 2, 0, 0, 8, 9, 12, 13, rf_t);
        push_win(2, 2, 0, 1, 10, 11, 14, 15, rf_t);
        ordy = 1'b1; dv = 1'b1;
        drain("img0");
        chk("idle_img1", img_idx, 1);
        chk("idle_req", mem_req, 0);
        chk("idle_valid", out_valid, 0);

        // image 1 with data_valid stalls
        ordy = 1'b0;
        push_win(0, 0, 1, 0, 16, 17, 20, 21, rf0);
        start = 1'b1; tick(); start = 1'b0;
        dv = 1'b1; tick();
        dv = 1'b0; tick();
        dv = 1'b0; tick();
        dv = 1'b1; tick();
        dv = 1'b0; tick();
        dv = 1'b1; tick();
        dv = 1'b1; tick();
        hold_checks(rf0, 0, 0, 1);
        push_win(2, 0, 1, 0, 18, 19, 22, 23, rf_t);
        push_win(0, 2, 1, 0, 24, 25, 28, 29, rf_t);
        push_win(2, 2, 1, 1, 26, 27, 30, 31, rf_t);
        ordy = 1'b1; dv = 1'b1;
        drain("img1");
        chk("wrap_img0", img_idx, 0);

        // image 0 again after wrap, first address must be 0
        push_win(0, 0, 0, 0, 0, 1, 4, 5, rf_t);
        push_win(2, 0, 0, 0, 2, 3, 6, 7, rf_t);
        push_win(0, 2, 0, 0, 8, 9, 12, 13, rf_t);
        push_win(2, 2, 0, 1, 10, 11, 14, 15, rf_t);
        start = 1'b1; tick(); start = 1'b0;
        drain("img0_again");
        chk("idle_img1b", img_idx, 1);

        // addr_clear in the same cycle as a handshake, image 1
        ordy = 1'b0;
        push_win(0, 0, 1, 0, 16, 17, 20, 21, rf_t);
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        ordy = 1'b1; addr_clear = 1'b1;
        tick();
        addr_clear = 1'b0; ordy = 1'b0;
        chk("clr_hs_valid", out_valid, 0);
        chk("clr_hs_req", mem_req, 0);
        chk("clr_hs_img", img_idx, 0);
        chk("clr_hs_rf", rf, 0);
        tick();
        chk("clr_hs_idle", mem_req, 0);

        // addr_clear mid-FETCH
        push_win(0, 0, 0, 0, 0, 1, 4, 5, rf_t);
        dv = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        tick();
        dv = 1'b0; addr_clear = 1'b1;
        tick();
        addr_clear = 1'b0;
        exp_addr.delete();
        exp_win.delete();
        chk("clr_f_req", mem_req, 0);
        chk("clr_f_addr", mem_addr, 0);
        chk("clr_f_valid", out_valid, 0);
        chk("clr_f_img", img_idx, 0);
        chk("clr_f_rf", rf, 0);

        // restart from 0, then reset mid-FETCH of the second window
        dv = 1'b1; ordy = 1'b1;
        push_win(0, 0, 0, 0, 0, 1, 4, 5, rf_t);
        exp_addr.push_back(16'd2);
        start = 1'b1; tick(); start = 1'b0;
        drain("restart");
        tick();
        chk("pre_rst_x", win_x, 2);
        rst = 1'b1;
        tick();
        chk("mrst_req", mem_req, 0);
        chk("mrst_addr", mem_addr, 0);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_last", last_win, 0);
        chk("mrst_x", win_x, 0);
        chk("mrst_y", win_y, 0);
        chk("mrst_img", img_idx, 0);
        chk("mrst_rf", rf, 0);
        rst = 1'b0;
        exp_addr.delete();
        exp_win.delete();
        ordy = 1'b0;
        tick();

        // two-channel instance: address order, window count, next image base
        exp_addr2.push_back(16'd0);  exp_addr2.push_back(16'd1);
        exp_addr2.push_back(16'd4);  exp_addr2.push_back(16'd5);
        exp_addr2.push_back(16'd16); exp_addr2.push_back(16'd17);
        exp_addr2.push_back(16'd20); exp_addr2.push_back(16'd21);
        exp_rf2.push_back({w(21), w(20), w(17), w(16), w(5), w(4), w(1), w(0)});
        win2_cnt = 0;
        start2 = 1'b1; tick(); start2 = 1'b0;
        n = 0;
        while (!seen_last2 && n < 400) begin
            tick();
            n++;
        end
        chk("win2_count", win2_cnt, 9);
        tick();
        chk("img2_next", img_idx2, 1);
        chk("req2_idle", mem_req2, 0);
        exp_addr2.push_back(16'd32);
        start2 = 1'b1; tick(); start2 = 1'b0;
        tick();
        chk("addr2_drained", exp_addr2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
